codec_config_seq: RTL and testbench

Sequencer that configures the WM8731 audio codec over I2C after power-on reset, then serves runtime single-register writes (volume, mute, path changes) from the rest of the design. It owns the I2C_SCLK/I2C_SDAT pins and sits beside the I2S datapath in the pedal top. It runs from CLOCK_50 and is released by the power-on reset_n.

---
 rtl/codec_config_seq_if.sv | 13 +
 rtl/codec_config_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_codec_config_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/codec_config_seq_if.sv
// rtl/codec_config_seq_if.sv - runtime write request and status bundle for codec_config_seq
interface codec_config_seq_if;
  logic       wr_req;
  logic [6:0] wr_reg;
  logic [8:0] wr_data;
  logic       wr_ack;
  logic       init_done;
  logic       error;
  logic       busy;

  modport master (output wr_req, wr_reg, wr_data, input wr_ack, init_done, error, busy);
  modport slave  (input wr_req, wr_reg, wr_data, output wr_ack, init_done, error, busy);
endinterface

// File: rtl/codec_config_seq.sv
// rtl/codec_config_seq.sv - WM8731 I2C init sequencer with runtime register writes
module codec_config_seq #(
  parameter int CLK_DIV   = 125,
  parameter int MAX_RETRY = 3
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  codec_config_seq_if.slave  cfg,
  output logic               I2C_SCLK,
  inout  wire                I2C_SDAT
);
  localparam int DW = $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_ERROR} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    ph_q, ph_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    retry_q, retry_d;
  logic [6:0]    reg_q, reg_d;
  logic [8:0]    dat_q, dat_d;
  logic          rt_q, rt_d;
  logic          nack_q, nack_d;
  logic          done_q, done_d;
  logic          scl_q, scl_d;
  logic          sda_low_q, sda_low_d;
  logic [1:0]    sda_sync_q, sda_sync_d;
  logic          tick, ack_pulse, launch;
  logic [7:0]    cur_byte;
  logic [15:0]   init_entry;

  function automatic logic [15:0] init_rom(input logic [3:0] i);
    case (i)
      4'd0:    return {7'd15, 9'h000};
      4'd1:    return {7'd0,  9'h017};
      4'd2:    return {7'd1,  9'h017};
      4'd3:    return {7'd2,  9'h079};
      4'd4:    return {7'd3,  9'h079};
      4'd5:    return {7'd4,  9'h012};
      4'd6:    return {7'd5,  9'h000};
      4'd7:    return {7'd6,  9'h000};
      4'd8:    return {7'd7,  9'h042};
      4'd9:    return {7'd8,  9'h000};
      default: return {7'd9,  9'h001};
    endcase
  endfunction

  assign tick       = (div_q == DW'(CLK_DIV - 1));
  assign init_entry = init_rom(idx_q);
  assign sda_sync_d = {sda_sync_q[0], I2C_SDAT};

  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = 8'h34;
      2'd1:    cur_byte = {reg_q, dat_q[8]};
      default: cur_byte = dat_q[7:0];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    div_d     = tick ? '0 : div_q + 1'b1;
    ph_d      = ph_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    reg_d     = reg_q;
    dat_d     = dat_q;
    rt_d      = rt_q;
    nack_d    = nack_q;
    done_d    = done_q;
    scl_d     = scl_q;
    sda_low_d = sda_low_q;
    ack_pulse = 1'b0;
    launch    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // runtime requests wait in place until the init table has been fully written
        if (!done_q) begin
          reg_d  = init_entry[15:9];
          dat_d  = init_entry[8:0];
          rt_d   = 1'b0;
          launch = 1'b1;
        end else if (cfg.wr_req) begin
          reg_d  = cfg.wr_reg;
          dat_d  = cfg.wr_data;
          rt_d   = 1'b1;
          launch = 1'b1;
        end
        if (launch) begin
          state_d = S_START;
          ph_d    = 2'd0;
          bit_d   = 3'd0;
          byte_d  = 2'd0;
          retry_d = 4'd0;
          nack_d  = 1'b0;
        end
      end
      S_START: if (tick) begin
        ph_d = ph_q + 2'd1;
        if (ph_q == 2'd0) sda_low_d = 1'b1;
        else begin
          scl_d   = 1'b0;
          state_d = S_BIT;
          ph_d    = 2'd0;
        end
      end
      S_BIT: if (tick) begin
        ph_d = ph_q + 2'd1;
        case (ph_q)
          2'd0: sda_low_d = ~cur_byte[3'd7 - bit_q];
          2'd1: scl_d = 1'b1;
          2'd2: ;
          default: begin
            scl_d = 1'b0;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_ACK;
          end
        endcase
      end
      S_ACK: if (tick) begin
        ph_d = ph_q + 2'd1;
        case (ph_q)
          2'd0: sda_low_d = 1'b0;
          2'd1: scl_d = 1'b1;
          2'd2: nack_d = sda_sync_q[1];
          default: begin
            scl_d = 1'b0;
            if (nack_q || byte_q == 2'd2) state_d = S_STOP;
            else begin
              byte_d  = byte_q + 2'd1;
              state_d = S_BIT;
            end
          end
        endcase
      end
      S_STOP: if (tick) begin
        ph_d = ph_q + 2'd1;
        case (ph_q)
          2'd0: sda_low_d = 1'b1;
          2'd1: scl_d = 1'b1;
          default: begin
            sda_low_d = 1'b0;
            ph_d      = 2'd0;
            // the final failed attempt still closes the bus before locking up
            if (nack_q && retry_q == 4'(MAX_RETRY)) state_d = S_ERROR;
            else state_d = S_GAP;
          end
        endcase
      end
      S_GAP: if (tick) begin
        ph_d = ph_q + 2'd1;
        if (ph_q == 2'd3) begin
          if (nack_q) begin
            retry_d = retry_q + 4'd1;
            nack_d  = 1'b0;
            byte_d  = 2'd0;
            bit_d   = 3'd0;
            state_d = S_START;
          end else begin
            ack_pulse = rt_q;
            if (!rt_q) begin
              idx_d = idx_q + 4'd1;
              if (idx_q == 4'd10) done_d = 1'b1;
            end
            state_d = S_IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      ph_q       <= 2'd0;
      bit_q      <= 3'd0;
      byte_q     <= 2'd0;
      idx_q      <= 4'd0;
      retry_q    <= 4'd0;
      reg_q      <= 7'd0;
      dat_q      <= 9'd0;
      rt_q       <= 1'b0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
      scl_q      <= 1'b1;
      sda_low_q  <= 1'b0;
      sda_sync_q <= 2'b11;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      reg_q      <= reg_d;
      dat_q      <= dat_d;
      rt_q       <= rt_d;
      nack_q     <= nack_d;
      done_q     <= done_d;
      scl_q      <= scl_d;
      sda_low_q  <= sda_low_d;
      sda_sync_q <= sda_sync_d;
    end
  end

  assign I2C_SCLK      = scl_q;
  assign I2C_SDAT      = sda_low_q ? 1'b0 : 1'bz;
  assign cfg.wr_ack    = ack_pulse;
  assign cfg.init_done = done_q;
  assign cfg.error     = (state_q == S_ERROR);
  assign cfg.busy      = (state_q inside {S_START, S_BIT, S_ACK, S_STOP, S_GAP});
endmodule

// File: tb/tb_codec_config_seq.sv
// tb/tb_codec_config_seq.sv - scoreboard bench for codec_config_seq with I2C slave model
module tb_codec_config_seq;
  localparam int CLK_DIV   = 4;
  localparam int MAX_RETRY = 3;
  localparam int TXN_CYC   = 117 * CLK_DIV;
  localparam int INIT_CYC  = 11 * TXN_CYC;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic slave_low = 1'b0;
  wire  scl;
  wire  sda;

  codec_config_seq_if cfg();

  codec_config_seq #(.CLK_DIV(CLK_DIV), .MAX_RETRY(MAX_RETRY)) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .cfg      (cfg),
    .I2C_SCLK (scl),
    .I2C_SDAT (sda)
  );

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [6:0] ireg [11] = '{7'd15, 7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8, 7'd9};
  logic [8:0] idat [11] = '{9'h000, 9'h017, 9'h017, 9'h079, 9'h079, 9'h012,
                            9'h000, 9'h000, 9'h042, 9'h000, 9'h001};
  logic [25:0] exp_q[$];

  // slave / bus-monitor state
  int   starts = 0, tx_no = 0, bitpos = 0, nb = 0, ack_cnt = 0;
  int   nack_mode = 0, nack_target = 0;
  logic nack_used = 1'b0, in_tx = 1'b0, ack_driven = 1'b0;
  logic [7:0] cur = 8'd0;
  logic [7:0] obs [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [25:0] full_txn(input logic [6:0] r, input logic [8:0] d);
    logic [7:0] b1, b2;
    b1 = 8'((int'(r) * 2) + (int'(d) / 256));
    b2 = 8'(int'(d) % 256);
    return {2'd3, 8'h34, b1, b2};
  endfunction

  function automatic logic [25:0] addr_nack_txn();
    return {2'd1, 8'h34, 16'h0000};
  endfunction

  initial begin : monitor
    logic ps, pd, s, d, nack;
    ps = 1'b1; pd = 1'b1;
    forever begin
      @(negedge clk);
      s = scl; d = sda;
      if (cfg.wr_ack) ack_cnt++;
      if (!reset_n) begin
        in_tx = 1'b0; bitpos = 0; slave_low = 1'b0; ack_driven = 1'b0;
      end else if (ps && s && pd && !d) begin
        in_tx = 1'b1; bitpos = 0; nb = 0; cur = 8'd0;
        obs[0] = 8'd0; obs[1] = 8'd0; obs[2] = 8'd0;
        tx_no = starts; starts++;
      end else if (ps && s && !pd && d) begin
        if (in_tx) begin
          if (exp_q.size() == 0) check("txn_unexpected", {6'd0, 2'(nb), obs[0], obs[1], obs[2]}, 32'h0);
          else check("txn_bytes", {6'd0, 2'(nb), obs[0], obs[1], obs[2]}, {6'd0, exp_q.pop_front()});
        end
        in_tx = 1'b0;
      end else if (!ps && s && in_tx) begin
        if (bitpos < 8) begin
          cur = {cur[6:0], d}; bitpos++;
        end else begin
          if (nb < 3) obs[nb] = cur;
          nb++; bitpos = 0;
        end
      end else if (ps && !s && in_tx) begin
        if (bitpos == 8 && !ack_driven) begin
          nack = (nack_mode == 2) ||
                 (nack_mode == 1 && nb == 0 && tx_no == nack_target && !nack_used);
          if (nack && nack_mode == 1) nack_used = 1'b1;
          slave_low = !nack; ack_driven = 1'b1;
        end else if (bitpos == 0 && ack_driven) begin
          slave_low = 1'b0; ack_driven = 1'b0;
        end
      end
      ps = s; pd = d;
    end
  end

  task automatic apply_reset(input int n, input int mode, input int target);
    reset_n = 1'b0;
    cfg.wr_req = 1'b0;
    repeat (n) @(negedge clk);
    exp_q.delete();
    starts = 0; nack_mode = mode; nack_target = target; nack_used = 1'b0;
  endtask

  task automatic push_init();
    for (int i = 0; i < 11; i++) exp_q.push_back(full_txn(ireg[i], idat[i]));
  endtask

  task automatic wait_init(input int budget, output int cyc);
    cyc = 0;
    while (!cfg.init_done && cyc < budget) begin @(negedge clk); cyc++; end
    check("init_done_reached", cfg.init_done, 1);
  endtask

  task automatic runtime_write(input logic [6:0] r, input logic [8:0] d);
    int n;
    n = 0;
    exp_q.push_back(full_txn(r, d));
    cfg.wr_reg = r; cfg.wr_data = d; cfg.wr_req = 1'b1;
    while (!cfg.wr_ack && n < 2 * TXN_CYC) begin @(negedge clk); n++; end
    check("wr_ack_seen", cfg.wr_ack, 1);
    cfg.wr_req = 1'b0;
    @(negedge clk);
    check("wr_ack_single_cycle", cfg.wr_ack, 0);
  endtask

  initial begin : stimulus
    int cyc, n, acks0, starts0, activity, k;
    logic [6:0] er;
    logic [8:0] ed;
    cfg.wr_req = 1'b0; cfg.wr_reg = 7'd0; cfg.wr_data = 9'd0;
    @(negedge clk);

    // reset values, then init with an early runtime request that must wait
    apply_reset(5, 0, 0);
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    check("rst_wr_ack", cfg.wr_ack, 0);
    check("rst_init_done", cfg.init_done, 0);
    check("rst_error", cfg.error, 0);
    check("rst_busy", cfg.busy, 0);
    er = 7'($urandom); ed = 9'($urandom);
    push_init();
    exp_q.push_back(full_txn(er, ed));
    reset_n = 1'b1;
    cyc = 0;
    while (!cfg.init_done && cyc < 2 * INIT_CYC) begin
      @(negedge clk); cyc++;
      if (cyc == 2) check("busy_after_release", cfg.busy, 1);
      if (cyc == 10) begin cfg.wr_reg = er; cfg.wr_data = ed; cfg.wr_req = 1'b1; end
    end
    check("init_done_reached", cfg.init_done, 1);
    check("init_time_window", ((cyc >= INIT_CYC - CLK_DIV) && (cyc <= INIT_CYC + CLK_DIV)), 1);
    check("no_ack_during_init", ack_cnt, 0);
    check("init_error_low", cfg.error, 0);
    n = 0;
    while (!cfg.wr_ack && n < 2 * TXN_CYC) begin @(negedge clk); n++; end
    check("early_req_acked", cfg.wr_ack, 1);
    cfg.wr_req = 1'b0;
    @(negedge clk);
    check("early_ack_single_cycle", cfg.wr_ack, 0);

    // runtime writes: the fixed case then randomized ones with random spacing
    runtime_write(7'h02, 9'h060);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 50)) @(negedge clk);
      runtime_write(7'($urandom), 9'($urandom));
    end
    repeat (3 * TXN_CYC) @(negedge clk);
    check("runtime_queue_drained", exp_q.size(), 0);
    check("runtime_ack_count", ack_cnt, 7);
    check("runtime_txn_count", starts, 11 + 7);
    check("sticky_init_done", cfg.init_done, 1);

    // reset mid-byte during R2, then a clean restart from R15
    apply_reset(2, 0, 0);
    for (int i = 0; i < 3; i++) exp_q.push_back(full_txn(ireg[i], idat[i]));
    reset_n = 1'b1;
    k = $urandom_range(1, 7);
    n = 0;
    while (!(starts == 4 && in_tx && nb == 1 && bitpos >= k) && n < 5 * TXN_CYC) begin
      @(negedge clk); n++;
    end
    check("reached_r2_mid_byte", (starts == 4 && in_tx), 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_scl_high", scl, 1);
    check("midrst_sda_released", sda, 1);
    check("midrst_busy_low", cfg.busy, 0);
    check("midrst_prior_txns_done", exp_q.size(), 0);
    apply_reset(3, 0, 0);
    push_init();
    reset_n = 1'b1;
    wait_init(2 * INIT_CYC, cyc);
    check("midrst_queue_drained", exp_q.size(), 0);

    // address byte of R4 NACKed once: R4 goes out again in full
    apply_reset(4, 1, 5);
    for (int i = 0; i < 5; i++) exp_q.push_back(full_txn(ireg[i], idat[i]));
    exp_q.push_back(addr_nack_txn());
    for (int i = 5; i < 11; i++) exp_q.push_back(full_txn(ireg[i], idat[i]));
    reset_n = 1'b1;
    wait_init(2 * INIT_CYC, cyc);
    check("nack1_txn_count", starts, 12);
    check("nack1_error_low", cfg.error, 0);
    check("nack1_queue_drained", exp_q.size(), 0);

    // slave NACKs everything: four attempts of R15 then terminal error
    apply_reset(4, 2, 0);
    for (int i = 0; i <= MAX_RETRY; i++) exp_q.push_back(addr_nack_txn());
    reset_n = 1'b1;
    n = 0;
    while (!cfg.error && n < 4 * TXN_CYC) begin @(negedge clk); n++; end
    check("nackall_error", cfg.error, 1);
    @(negedge clk);
    check("nackall_init_done_low", cfg.init_done, 0);
    check("nackall_busy_low", cfg.busy, 0);
    check("nackall_attempts", starts, MAX_RETRY + 1);
    acks0 = ack_cnt; starts0 = starts; activity = 0;
    cfg.wr_reg = 7'($urandom); cfg.wr_data = 9'($urandom); cfg.wr_req = 1'b1;
    repeat (4000) begin
      @(negedge clk);
      if (!scl || !sda || cfg.busy) activity++;
    end
    cfg.wr_req = 1'b0;
    check("nackall_bus_idle", activity, 0);
    check("nackall_no_new_txn", starts, starts0);
    check("nackall_no_ack", ack_cnt, acks0);
    check("nackall_error_sticky", cfg.error, 1);
    check("nackall_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
